// File: rtl/palette_pkg.sv
// Shared types and constants for the palette lookup: FSM states, fade level
// constants and the power-on default palette (12-bit 0xRGB, 4 bits per channel).
package palette_pkg;

    typedef enum logic [1:0] {
        INIT = 2'd0,
        IDLE = 2'd1,
        FADE = 2'd2
    } pal_state_t;

    localparam logic [4:0] LVL_MAX   = 5'd16;
    localparam int         LVL_SHIFT = 4;

    localparam logic [11:0] DEFAULT_PAL [16] = '{
        12'h000, 12'h888, 12'hBBB, 12'hF20,
        12'h2E3, 12'h0DF, 12'hEEE, 12'h333,
        12'hEB2, 12'hFF9, 12'h121, 12'h871,
        12'h2A2, 12'hFFF, 12'h910, 12'h777
    };

    // Entries beyond the 16-colour default table power up black.
    function automatic logic [11:0] default_pal_at(input int k);
        if (k < 16) begin
            return DEFAULT_PAL[k[3:0]];
        end
        return 12'h000;
    endfunction

endpackage

// File: rtl/palette_scale.sv
// One colour channel scaled by a 0..16 fade level: (c * level) >> 4.
// With PALETTE_FADE_EN undefined the channel passes through unscaled.
module palette_scale
    import palette_pkg::*;
#(
    parameter int CH_W = 4
) (
    input  logic [CH_W-1:0] c,
    input  logic [4:0]      level,
    output logic [CH_W-1:0] scaled
);

`ifdef PALETTE_FADE_EN
    logic [CH_W+4:0] prod;
    logic            unused_prod;

    // level <= 16 keeps the product below 2**(CH_W+4), so the top bit is always 0.
    assign prod        = (CH_W+5)'(c) * (CH_W+5)'(level);
    assign scaled      = prod[LVL_SHIFT +: CH_W];
    assign unused_prod = ^{prod[LVL_SHIFT-1:0], prod[CH_W+4]};
`else
    logic unused_level;

    assign scaled       = c;
    assign unused_level = ^level;
`endif

endmodule

// File: rtl/palette_lut.sv
// Palette lookup with power-on default load, write port and optional fade
// (enabled by defining PALETTE_FADE_EN). Lookup latency is two cycles.
module palette_lut
    import palette_pkg::*;
#(
    parameter int IDX_W    = 4,
    parameter int CH_W     = 4,
    parameter int FADE_DIV = 4
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic [IDX_W-1:0]   index,
    input  logic               index_valid,
    output logic [CH_W-1:0]    red,
    output logic [CH_W-1:0]    green,
    output logic [CH_W-1:0]    blue,
    output logic               rgb_valid,
    input  logic               wr_valid,
    output logic               wr_ready,
    input  logic [IDX_W-1:0]   wr_addr,
    input  logic [3*CH_W-1:0]  wr_data,
    input  logic               fade_start,
    input  logic               fade_dir,
    output logic               fade_busy,
    output logic [4:0]         fade_level
);

    localparam int ENTRIES = 2**IDX_W;
    localparam int DW      = 3*CH_W;

    pal_state_t       state_reg, state_next;
    logic [IDX_W-1:0] init_cnt_reg, init_cnt_next;

`ifdef PALETTE_FADE_EN
    localparam int DIV_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    logic [4:0]       level_reg, level_next;
    logic [4:0]       target_reg, target_next;
    logic [DIV_W-1:0] div_reg, div_next;
    logic [4:0]       level_step;
    logic [4:0]       fade_target;

    assign level_step  = (target_reg > level_reg) ? level_reg + 5'd1 : level_reg - 5'd1;
    assign fade_target = fade_dir ? LVL_MAX : 5'd0;
    assign fade_level  = level_reg;
    assign fade_busy   = (state_reg == FADE);
`else
    localparam int unused_fade_div = FADE_DIV;
    logic unused_fade_in;

    assign unused_fade_in = ^{fade_start, fade_dir};
    assign fade_level     = LVL_MAX;
    assign fade_busy      = 1'b0;
`endif

    assign wr_ready = (state_reg != INIT);

    // ---------------- control FSM ----------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_reg    <= INIT;
            init_cnt_reg <= '0;
`ifdef PALETTE_FADE_EN
            level_reg    <= LVL_MAX;
            target_reg   <= LVL_MAX;
            div_reg      <= '0;
`endif
        end else begin
            state_reg    <= state_next;
            init_cnt_reg <= init_cnt_next;
`ifdef PALETTE_FADE_EN
            level_reg    <= level_next;
            target_reg   <= target_next;
            div_reg      <= div_next;
`endif
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
`ifdef PALETTE_FADE_EN
        level_next    = level_reg;
        target_next   = target_reg;
        div_next      = div_reg;
`endif
        case (state_reg)
            INIT: begin
                init_cnt_next = init_cnt_reg + 1'b1;
                if (init_cnt_reg == IDX_W'(ENTRIES-1)) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
`ifdef PALETTE_FADE_EN
                if (fade_start) begin
                    target_next = fade_target;
                    div_next    = '0;
                    if (fade_target != level_reg) begin
                        state_next = FADE;
                    end
                end
`endif
            end
            FADE: begin
`ifdef PALETTE_FADE_EN
                // fade_start is deliberately not looked at while a fade runs.
                if (div_reg == DIV_W'(FADE_DIV-1)) begin
                    div_next   = '0;
                    level_next = level_step;
                    if (level_step == target_reg) begin
                        state_next = IDLE;
                    end
                end else begin
                    div_next = div_reg + 1'b1;
                end
`else
                state_next = IDLE;
`endif
            end
            default: begin
                state_next = INIT;
            end
        endcase
    end

    // ---------------- default palette expansion ----------------
    logic [11:0]   init_pal;
    logic [DW-1:0] init_data;

    assign init_pal = default_pal_at(int'(init_cnt_reg));

    for (genvar gi = 0; gi < 3; gi++) begin : g_init_ch
        logic [3:0] nib;
        assign nib = init_pal[4*gi +: 4];
        if (CH_W >= 4) begin : g_ext
            assign init_data[CH_W*gi +: CH_W] = CH_W'(nib);
        end else begin : g_trunc
            assign init_data[CH_W*gi +: CH_W] = nib[3 -: CH_W];
        end
    end

    // ---------------- colour storage ----------------
    logic [DW-1:0]    mem [ENTRIES];
    logic             mem_we;
    logic [IDX_W-1:0] mem_waddr;
    logic [DW-1:0]    mem_wdata;
    logic [DW-1:0]    rd_data_reg;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
        if (state_reg == INIT) begin
            mem_we    = 1'b1;
            mem_waddr = init_cnt_reg;
            mem_wdata = init_data;
        end else if (wr_valid) begin
            mem_we = 1'b1;
        end
    end

    // Read and write share the edge; the read sees the pre-write contents.
    always_ff @(posedge Clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
        rd_data_reg <= mem[index];
    end

    // ---------------- lookup pipeline ----------------
    logic            valid1_reg;
    logic [4:0]      lvl1;
    logic [CH_W-1:0] ch_scaled [3];
    logic [CH_W-1:0] red_reg, green_reg, blue_reg;
    logic            rgb_valid_reg;

`ifdef PALETTE_FADE_EN
    logic [4:0] lvl1_reg;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            lvl1_reg <= LVL_MAX;
        end else begin
            lvl1_reg <= level_reg;
        end
    end

    assign lvl1 = lvl1_reg;
`else
    assign lvl1 = LVL_MAX;
`endif

    for (genvar gi = 0; gi < 3; gi++) begin : g_scale
        palette_scale #(
            .CH_W (CH_W)
        ) u_scale (
            .c      (rd_data_reg[CH_W*gi +: CH_W]),
            .level  (lvl1),
            .scaled (ch_scaled[gi])
        );
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            valid1_reg    <= 1'b0;
            rgb_valid_reg <= 1'b0;
            red_reg       <= '0;
            green_reg     <= '0;
            blue_reg      <= '0;
        end else begin
            valid1_reg    <= index_valid && (state_reg != INIT);
            rgb_valid_reg <= valid1_reg;
            red_reg       <= ch_scaled[2];
            green_reg     <= ch_scaled[1];
            blue_reg      <= ch_scaled[0];
        end
    end

    assign red       = red_reg;
    assign green     = green_reg;
    assign blue      = blue_reg;
    assign rgb_valid = rgb_valid_reg;

endmodule

// File: tb/tb_palette_lut.sv
// Self-checking bench for palette_lut: directed init/write/fade/reset steps
// plus a randomized lookup/write phase against a palette array model.
module tb_palette_lut;

    localparam int IDX_W    = 4;
    localparam int CH_W     = 4;
    localparam int FADE_DIV = 4;
    localparam int ENTRIES  = 16;
`ifdef PALETTE_FADE_EN
    localparam bit FADE_EN = 1'b1;
`else
    localparam bit FADE_EN = 1'b0;
`endif

    localparam logic [11:0] DEF_PAL [16] = '{
        12'h000, 12'h888, 12'hBBB, 12'hF20, 12'h2E3, 12'h0DF, 12'hEEE, 12'h333,
        12'hEB2, 12'hFF9, 12'h121, 12'h871, 12'h2A2, 12'hFFF, 12'h910, 12'h777
    };

    logic             Clk = 1'b0;
    logic             Reset = 1'b1;
    logic [IDX_W-1:0] index = '0;
    logic             index_valid = 1'b0;
    logic [CH_W-1:0]  red, green, blue;
    logic             rgb_valid;
    logic             wr_valid = 1'b0;
    logic             wr_ready;
    logic [IDX_W-1:0] wr_addr = '0;
    logic [11:0]      wr_data = '0;
    logic             fade_start = 1'b0;
    logic             fade_dir = 1'b0;
    logic             fade_busy;
    logic [4:0]       fade_level;

    int compared   = 0;
    int mismatched = 0;
    logic [11:0] pal [16];

    palette_lut #(
        .IDX_W    (IDX_W),
        .CH_W     (CH_W),
        .FADE_DIV (FADE_DIV)
    ) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .index       (index),
        .index_valid (index_valid),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .rgb_valid   (rgb_valid),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .fade_start  (fade_start),
        .fade_dir    (fade_dir),
        .fade_busy   (fade_busy),
        .fade_level  (fade_level)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected colour for a stored entry viewed at a given fade level.
    function automatic logic [11:0] scale12(input logic [11:0] c, input int lvl);
        int r = int'(c[11:8]);
        int g = int'(c[7:4]);
        int b = int'(c[3:0]);
        return {4'((r * lvl) / 16), 4'((g * lvl) / 16), 4'((b * lvl) / 16)};
    endfunction

    function automatic int fade_down_level(input int k);
        int l = 16 - k / FADE_DIV;
        if (!FADE_EN) return 16;
        return (l < 0) ? 0 : l;
    endfunction

    task automatic lookup(input string tag, input int idx, input int lvl);
        logic [11:0] exp = scale12(pal[idx], lvl);
        index = IDX_W'(idx);
        index_valid = 1'b1;
        step();
        index_valid = 1'b0;
        step();
        check({tag, "_valid"}, 32'(rgb_valid), 32'd1);
        check(tag, 32'({red, green, blue}), 32'(exp));
        $display("lookup %s idx=%0d rgb=%03h", tag, idx, {red, green, blue});
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_lvl"},   32'(fade_level), 32'd16);
        check({tag, "_busy"},  32'(fade_busy), 32'd0);
        check({tag, "_rv"},    32'(rgb_valid), 32'd0);
        check({tag, "_rgb"},   32'({red, green, blue}), 32'd0);
        check({tag, "_ready"}, 32'(wr_ready), 32'd0);
        $display("reset %s checked", tag);
    endtask

    // Release Reset and count cycles until wr_ready; lookups during INIT must be dropped.
    task automatic init_and_count(input string tag);
        int n = 0;
        index = 4'd7;
        index_valid = 1'b1;
        Reset = 1'b0;
        while (wr_ready !== 1'b1 && n < 100) begin
            step();
            n++;
            check({tag, "_init_rv"}, 32'(rgb_valid), 32'd0);
        end
        index_valid = 1'b0;
        check({tag, "_cycles"}, 32'(n), 32'(ENTRIES));
        $display("init %s wr_ready after %0d cycles", tag, n);
        for (int i = 0; i < 16; i++) pal[i] = DEF_PAL[i];
    endtask

    initial begin
        logic        prev_v, cur_v, w;
        logic [11:0] prev_c, cur_c;
        int          idx, waddr;

        repeat (3) @(posedge Clk);
        #1;
        check_reset_state("por");
        init_and_count("por");

        lookup("idx13", 13, 16);
        lookup("idx3", 3, 16);

        // Write and lookup to the same address in one cycle.
        index = 4'd5; index_valid = 1'b1;
        wr_addr = 4'd5; wr_data = 12'h123; wr_valid = 1'b1;
        step();
        index_valid = 1'b0; wr_valid = 1'b0;
        step();
        check("rbw_valid", 32'(rgb_valid), 32'd1);
        check("rbw_old", 32'({red, green, blue}), 32'(pal[5]));
        $display("rbw same-cycle rgb=%03h", {red, green, blue});
        pal[5] = 12'h123;
        lookup("rbw_new", 5, 16);

        // Fade toward black, with an ignored fade_start mid-way and a lookup at level 8.
        fade_dir = 1'b0; fade_start = 1'b1;
        step();
        fade_start = 1'b0;
        check("fade_dn_busy0", 32'(fade_busy), 32'(FADE_EN));
        for (int k = 1; k <= 64; k++) begin
            if (k == 10) begin fade_dir = 1'b1; fade_start = 1'b1; end
            if (k == 33) begin index = 4'd1; index_valid = 1'b1; end
            step();
            fade_start = 1'b0; fade_dir = 1'b0; index_valid = 1'b0;
            check("fade_dn_lvl", 32'(fade_level), 32'(fade_down_level(k)));
            check("fade_dn_busy", 32'(fade_busy), 32'(FADE_EN && k < 64));
            if (k == 34) begin
                check("lvl8_valid", 32'(rgb_valid), 32'd1);
                check("lvl8_rgb", 32'({red, green, blue}), 32'(scale12(pal[1], FADE_EN ? 8 : 16)));
            end
            $display("fade_dn k=%0d level=%0d busy=%0b", k, fade_level, fade_busy);
        end
        lookup("black13", 13, FADE_EN ? 0 : 16);

        // Fade back up to full, then a redundant fade-up that must not start.
        fade_dir = 1'b1; fade_start = 1'b1;
        step();
        fade_start = 1'b0;
        repeat (63) step();
        check("fade_up_busy63", 32'(fade_busy), 32'(FADE_EN));
        step();
        check("fade_up_lvl", 32'(fade_level), 32'd16);
        check("fade_up_busy", 32'(fade_busy), 32'd0);
        $display("fade_up done level=%0d busy=%0b", fade_level, fade_busy);
        fade_start = 1'b1;
        step();
        fade_start = 1'b0; fade_dir = 1'b0;
        check("noop_busy", 32'(fade_busy), 32'd0);
        check("noop_lvl", 32'(fade_level), 32'd16);
        $display("noop fade level=%0d busy=%0b", fade_level, fade_busy);

        // Randomized writes and lookups, level 16, scoreboard two cycles deep.
        prev_v = 1'b0; prev_c = '0;
        for (int i = 0; i < 300; i++) begin
            cur_v = 1'($urandom_range(0, 1));
            idx   = int'($urandom_range(0, 15));
            w     = ($urandom_range(0, 2) == 0);
            waddr = ($urandom_range(0, 3) == 0) ? idx : int'($urandom_range(0, 15));
            index = IDX_W'(idx); index_valid = cur_v;
            wr_valid = w; wr_addr = IDX_W'(waddr); wr_data = 12'($urandom);
            cur_c = scale12(pal[idx], 16);
            if (w) pal[waddr] = wr_data;
            step();
            check("rnd_valid", 32'(rgb_valid), 32'(prev_v));
            if (prev_v) check("rnd_rgb", 32'({red, green, blue}), 32'(prev_c));
            $display("rnd %0d idx=%0d v=%0b wr=%0b@%0d rgb=%03h", i, idx, cur_v, w, waddr, {red, green, blue});
            prev_v = cur_v; prev_c = cur_c;
        end
        index_valid = 1'b0; wr_valid = 1'b0;
        step();
        check("rnd_tail_valid", 32'(rgb_valid), 32'(prev_v));
        if (prev_v) check("rnd_tail_rgb", 32'({red, green, blue}), 32'(prev_c));

        // Reset in the middle of a fade discards user writes and reloads defaults.
        wr_addr = 4'd2; wr_data = 12'h000; wr_valid = 1'b1;
        step();
        wr_valid = 1'b0;
        pal[2] = 12'h000;
        lookup("wr2", 2, 16);
        fade_dir = 1'b0; fade_start = 1'b1;
        step();
        fade_start = 1'b0;
        repeat (10) step();
        Reset = 1'b1;
        #1;
        check_reset_state("midfade");
        step();
        step();
        init_and_count("midfade");
        lookup("reinit2", 2, 16);
        lookup("reinit5", 5, 16);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
